tt_um_power_seq: RTL and testbench
==================================

TT_UM_POWER_SEQ -- requirements
Module: tt_um_power_seq

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the operand LFSR value after reset and on every START.
REQ-002 SHALL have parameter BURST_UNIT, default 16, meaning the cycles per burst/gap length code step.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port ena, input, 1, design enable; low freezes all state except the input synchronizers.
REQ-006 SHALL have port ui_in, input, 8: [0] start, [1] stop, [3:2] density mode, [7:4] burst length code.
REQ-007 SHALL have port uio_in, input, 8: [3:0] gap length code; [7:4] ignored.
REQ-008 SHALL have port uo_out, output, 8, the registered sum of the shared 7-bit adder.
REQ-009 SHALL have port uio_out, output, 8: [3:0]=0, [4] busy, [5] in_burst, [6] in_gap, [7] done (sticky).
REQ-010 SHALL have port uio_oe, output, 8, driven to the constant 8'hF0.

Function
REQ-011 SHALL pass ui_in[1:0] through a 2-flop synchronizer; start = rising edge of synced bit0; stop = synced bit1 level.
REQ-012 SHALL implement FSM IDLE, BURST, GAP.
REQ-013 SHALL leave IDLE only on start; on start, capture burst_len=(ui_in[7:4]+1)*BURST_UNIT, gap_len=uio_in[3:0]*BURST_UNIT, mode=ui_in[3:2]; reload the LFSR with LFSR_SEED; clear done; enter BURST.
REQ-014 SHALL ignore start when not in IDLE.
REQ-015 SHALL decrement the cycle counter in BURST; on expiry, enter GAP if gap_len!=0, else enter IDLE with done=1.
REQ-016 SHALL leave GAP after exactly gap_len cycles and enter BURST with the counter reloaded; repetition continues until stop.
REQ-017 SHALL, with stop asserted in BURST or GAP, enter IDLE on the next edge and set done=1; stop SHALL take priority over start and over counter expiry in the same cycle.
REQ-018 SHALL hold 7-bit operand registers A and B; uo_out SHALL be the registered zero-extended A+B (8 bits, no overflow loss), one cycle after the operands.
REQ-019 SHALL step the 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) once per cycle, in BURST only.
REQ-020 SHALL, in BURST, load A<=lfsr[6:0] and B<=lfsr[13:7] at a rate set by mode: 00 never (held); 01 every 4th burst cycle; 10 every 2nd; 11 every cycle; rate phase SHALL restart at 0 on each BURST entry.
REQ-021 SHALL hold A and B during GAP, and clear them to 0 on entering IDLE.
REQ-022 SHALL assert busy when not in IDLE, in_burst in BURST, in_gap in GAP; done SHALL remain set until the next accepted start.
REQ-023 SHALL, while ena=0, hold the FSM, counters, LFSR, operands and outputs; an edge occurring during ena=0 SHALL be detected when ena returns high only if the synced level still differs from the stored previous value.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force IDLE, the counters, A, B, uo_out, done and the synchronizers to 0, and the LFSR to LFSR_SEED.
REQ-025 SHALL, with rst_n asserted mid-burst, zero uo_out and uio_out[7:4] immediately without waiting for a clock.

Structure
REQ-026 SHALL place the state enum, mode encodings (STATIC, QUARTER, HALF, FULL), the LFSR tap mask and the default seed in package tt_power_pkg.
REQ-027 SHALL implement the LFSR as sub-module tt_lfsr16 with inputs clk, rst_n, load, step and output state[15:0].

Verification
REQ-028 SHALL test: ui_in=8'h0D (mode 11, code 0), uio_in=0, then pulse bit0 -> busy rises 3 edges later; in_burst for exactly 16 cycles; then IDLE with done=1 and uo_out=0.
REQ-029 SHALL test: mode 10, burst code 1, gap code 2 -> a 32-cycle burst in which operands change every 2nd cycle, a 32-cycle gap with uo_out constant, then a burst again.
REQ-030 SHALL test: stop asserted at burst cycle 5 together with a start edge -> IDLE on the next edge, done=1, start ignored.
REQ-031 SHALL test: mode 00 -> uo_out constant at its value after the first load throughout the burst.
REQ-032 SHALL test: ena low for 10 cycles mid-burst -> the remaining burst length is unchanged after resume and the LFSR sequence continues without a skip.
REQ-033 SHALL test: rst_n pulled low mid-gap -> uio_out=8'h00 and uo_out=0 asynchronously; the first post-reset operands equal the LFSR_SEED-derived values.

Source files
------------

// File: rtl/tt_power_pkg.sv
// Shared types and constants for the burst/gap power-load sequencer.
package tt_power_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STATIC  = 2'd0,
    QUARTER = 2'd1,
    HALF    = 2'd2,
    FULL    = 2'd3
  } mode_t;

  // Galois right-shift mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Whether the operand registers reload in the current burst phase
  function automatic logic load_due(input mode_t m, input logic [1:0] ph);
    case (m)
      STATIC:  return 1'b0;
      QUARTER: return (ph == 2'd0);
      HALF:    return ~ph[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/tt_lfsr16.sv
// 16-bit Galois LFSR with synchronous reload to the seed.
module tt_lfsr16
  import tt_power_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/tt_um_power_seq.sv
// Burst/gap sequencer toggling a shared 7-bit adder with LFSR operands.
module tt_um_power_seq
  import tt_power_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED,
  parameter int unsigned BURST_UNIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic             start_prev;
  logic             start_edge;
  logic             stop_lvl;
  state_t           state;
  mode_t            mode;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] burst_len;
  logic [CNT_W-1:0] gap_len;
  logic [CNT_W-1:0] new_burst_len;
  logic [CNT_W-1:0] new_gap_len;
  logic [1:0]       phase;
  logic [6:0]       op_a;
  logic [6:0]       op_b;
  logic             done;
  logic [15:0]      lfsr_q;
  logic             lfsr_load;
  logic             lfsr_step;
  logic             unused_uio;

  assign unused_uio = ^uio_in[7:4];

  // Synchronizers keep running while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= ui_in[1:0];
      sync2 <= sync1;
    end
  end

  assign start_edge    = sync2[0] & ~start_prev;
  assign stop_lvl      = sync2[1];
  assign new_burst_len = (CNT_W'(ui_in[7:4]) + CNT_W'(1)) * CNT_W'(BURST_UNIT);
  assign new_gap_len   = CNT_W'(uio_in[3:0]) * CNT_W'(BURST_UNIT);
  assign lfsr_load     = ena & (state == IDLE) & start_edge;
  assign lfsr_step     = ena & (state == BURST);

  tt_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .state (lfsr_q)
  );

  // Sequencer, counters, operands and sum register; stop beats expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b0;
      state      <= IDLE;
      mode       <= STATIC;
      cnt        <= '0;
      burst_len  <= '0;
      gap_len    <= '0;
      phase      <= 2'd0;
      op_a       <= 7'd0;
      op_b       <= 7'd0;
      done       <= 1'b0;
      uo_out     <= 8'd0;
    end else if (ena) begin
      start_prev <= sync2[0];
      uo_out     <= {1'b0, op_a} + {1'b0, op_b};
      case (state)
        IDLE: begin
          if (start_edge) begin
            burst_len <= new_burst_len;
            gap_len   <= new_gap_len;
            mode      <= mode_t'(ui_in[3:2]);
            cnt       <= new_burst_len - CNT_W'(1);
            phase     <= 2'd0;
            done      <= 1'b0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (load_due(mode, phase)) begin
            op_a <= lfsr_q[6:0];
            op_b <= lfsr_q[13:7];
          end
          phase <= phase + 2'd1;
          if (stop_lvl || (cnt == '0 && gap_len == '0)) begin
            state <= IDLE;
            done  <= 1'b1;
            cnt   <= '0;
            op_a  <= 7'd0;
            op_b  <= 7'd0;
          end else if (cnt == '0) begin
            state <= GAP;
            cnt   <= gap_len - CNT_W'(1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (stop_lvl) begin
            state <= IDLE;
            done  <= 1'b1;
            cnt   <= '0;
            op_a  <= 7'd0;
            op_b  <= 7'd0;
          end else if (cnt == '0) begin
            state <= BURST;
            cnt   <= burst_len - CNT_W'(1);
            phase <= 2'd0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uio_out = {done, (state == GAP), (state == BURST), (state != IDLE), 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_power_seq.sv
// Directed self-checking bench for the burst/gap power sequencer.
module tb_tt_um_power_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  wire busy     = uio_out[4];
  wire in_burst = uio_out[5];
  wire in_gap   = uio_out[6];
  wire done     = uio_out[7];

  int checks = 0;
  int errors = 0;
  logic [7:0] hist [0:511];

  tt_um_power_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns at the first BURST sample
  task automatic start_pulse(input logic [7:0] base);
    ui_in = base | 8'h01;
    tick();
    ui_in = base;
    tick();
    tick();
  endtask

  // Record uo_out while the chosen phase flag stays high
  task automatic measure(input bit gap, output int n);
    n = 0;
    while (n < 300 && (gap ? in_gap : in_burst)) begin
      hist[n] = uo_out;
      n++;
      tick();
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < k; i++) s = lfsr_next(s);
    return s;
  endfunction

  function automatic logic [7:0] opsum(input logic [15:0] s);
    return {1'b0, s[6:0]} + {1'b0, s[13:7]};
  endfunction

  initial begin
    int n;
    int bad;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) tick();
    check("rst_uo", 32'(uo_out), 32'h00);
    check("rst_uio", 32'(uio_out), 32'h00);
    check("rst_oe", 32'(uio_oe), 32'hF0);
    rst_n = 1'b1;
    tick();

    // Mode 11, code 0, no gap: 16-cycle burst then done
    ui_in = 8'h0C;
    tick();
    tick();
    ui_in = 8'h0D;
    tick();
    ui_in = 8'h0C;
    check("t1_busy_e1", 32'(busy), 32'd0);
    tick();
    check("t1_busy_e2", 32'(busy), 32'd0);
    tick();
    check("t1_busy_e3", 32'(busy), 32'd1);
    measure(1'b0, n);
    check("t1_burst_len", 32'(n), 32'd16);
    check("t1_sum_seed", 32'(hist[2]), 32'hBA);
    check("t1_sum_s1", 32'(hist[3]), 32'hB4);
    check("t1_sum_s13", 32'(hist[15]), 32'(opsum(lfsr_at(13))));
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    tick();
    tick();
    check("t1_uo_zero", 32'(uo_out), 32'd0);
    check("t1_done_sticky", 32'(done), 32'd1);

    // Mode 10, burst code 1, gap code 2: repeating 32/32
    uio_in = 8'h02;
    start_pulse(8'h18);
    check("t2_done_clr", 32'(done), 32'd0);
    measure(1'b0, n);
    check("t2_burst_len", 32'(n), 32'd32);
    check("t2_sum_c0", 32'(hist[2]), 32'hBA);
    check("t2_hold_c1", 32'(hist[3]), 32'hBA);
    check("t2_sum_c2", 32'(hist[4]), 32'(opsum(lfsr_at(2))));
    bad = 0;
    for (int k = 3; k < 32; k += 2) if (hist[k] !== hist[k-1]) bad++;
    check("t2_half_rate", 32'(bad), 32'd0);
    check("t2_in_gap", 32'(in_gap), 32'd1);
    measure(1'b1, n);
    check("t2_gap_len", 32'(n), 32'd32);
    bad = 0;
    for (int k = 0; k < 32; k++) if (hist[k] !== opsum(lfsr_at(30))) bad++;
    check("t2_gap_const", 32'(bad), 32'd0);
    check("t2_reburst", 32'(in_burst), 32'd1);
    ui_in = 8'h1A;
    repeat (3) tick();
    check("t2_stop_idle", 32'(busy), 32'd0);
    check("t2_stop_done", 32'(done), 32'd1);
    ui_in = 8'h18;
    repeat (3) tick();

    // Stop together with a start edge at burst cycle 5
    uio_in = 8'h00;
    ui_in  = 8'h0C;
    start_pulse(8'h0C);
    repeat (3) tick();
    ui_in = 8'h0F;
    tick();
    check("t3_c4_burst", 32'(in_burst), 32'd1);
    tick();
    check("t3_c5_burst", 32'(in_burst), 32'd1);
    tick();
    check("t3_stop_idle", 32'(busy), 32'd0);
    check("t3_stop_done", 32'(done), 32'd1);
    bad = 0;
    repeat (4) begin
      tick();
      if (busy !== 1'b0) bad++;
    end
    check("t3_start_ignored", 32'(bad), 32'd0);
    ui_in = 8'h0C;
    repeat (3) tick();

    // Mode 00: operands never load
    ui_in = 8'h00;
    start_pulse(8'h00);
    measure(1'b0, n);
    check("t4_burst_len", 32'(n), 32'd16);
    bad = 0;
    for (int k = 1; k < 16; k++) if (hist[k] !== hist[0]) bad++;
    check("t4_uo_const", 32'(bad), 32'd0);
    check("t4_uo_val", 32'(hist[0]), 32'd0);

    // ena low for 10 cycles during burst cycle 3
    ui_in = 8'h0C;
    start_pulse(8'h0C);
    repeat (3) tick();
    ena = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (in_burst !== 1'b1 || uo_out !== 8'hB4) bad++;
    end
    check("t5_frozen", 32'(bad), 32'd0);
    ena = 1'b1;
    measure(1'b0, n);
    check("t5_remaining", 32'(n), 32'd13);
    bad = 0;
    for (int j = 0; j < 13; j++) if (hist[j] !== opsum(lfsr_at(1 + j))) bad++;
    check("t5_lfsr_cont", 32'(bad), 32'd0);

    // Async reset in the middle of a gap
    uio_in = 8'h01;
    start_pulse(8'h0C);
    measure(1'b0, n);
    check("t6_burst_len", 32'(n), 32'd16);
    repeat (5) tick();
    check("t6_in_gap", 32'(in_gap), 32'd1);
    rst_n = 1'b0;
    #2;
    check("t6_async_uio", 32'(uio_out), 32'h00);
    check("t6_async_uo", 32'(uo_out), 32'h00);
    tick();
    rst_n  = 1'b1;
    uio_in = 8'h00;
    tick();
    start_pulse(8'h0C);
    measure(1'b0, n);
    check("t6_post_len", 32'(n), 32'd16);
    check("t6_post_seed", 32'(hist[2]), 32'hBA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
